traffic_conflict_monitor: RTL and testbench
===========================================

# traffic_conflict_monitor

Independent safety monitor on the six lamp outputs of the traffic light controller (`top`). It decodes the lamp pattern back into a phase and checks lamp integrity, main/side conflicts, the legal phase sequence and phase dwell times. On any violation it latches a sticky fault code and drives a flashing-red enable that the lamp driver uses to override the controller.

## Interface
- `GREEN_LIFETIME`, default 10: maximum side-green dwell, in cycles.
- `YELLOW_LIFETIME`, default 3: required yellow dwell, in cycles.
- `FLASH_HALF`, default 4: half-period of the `flash` toggle, in cycles.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `main_red`, `main_yellow`, `main_green`  in  1 each  main road lamps, from the controller.
- `side_red`, `side_yellow`, `side_green`  in  1 each  side road lamps, from the controller.
- `clear_fault`  in  1  request to clear a latched fault.
- `phase`  out  2  decoded phase of the last sample.
- `phase_valid`  out  1  last sample decoded to a legal phase.
- `fault`  out  1  sticky fault flag.
- `fault_code`  out  3  code of the first fault; 0 means none.
- `flash`  out  1  flashing-red enable.

## Operation
- **Input register:** the six lamps are registered every cycle. All checks use the registered sample S and the previous sample's decoded phase P.
- **Phase decode of S:**
  - 00: main green, side red.
  - 10: main yellow, side red.
  - 11: main red, side green.
  - 01: main red, side yellow.
  - Any other pattern: `phase_valid`=0 and `phase` holds its last value.
- **Legal transitions:** 00→10, 10→11, 11→01, 01→00, and X→X (hold).
  - Any X→00 is also legal, because the controller's reset preempts to main green.
- **Dwell counter:**
  - Loads 1 when the phase changes or on the first valid sample.
  - Increments while the phase holds.
  - Saturates at GREEN_LIFETIME+YELLOW_LIFETIME+2.
  - Cleared to 0 on an invalid sample.
  - Width is `$clog2` of the saturation value plus 1.
- **Fault checks, in priority order (lowest code wins on a same-cycle tie):**
  - 1 (lamp integrity): a road does not have exactly one lamp lit.
  - 2 (conflict): both roads non-red.
  - 3 (illegal transition): P valid, S valid, and P→S is not in the legal set.
  - 4 (yellow timing): in phase 10 or 01 the dwell would reach YELLOW_LIFETIME+1; or a 10→11 transition happens with yellow dwell < YELLOW_LIFETIME.
  - 5 (side green overrun): in phase 11 the dwell would reach GREEN_LIFETIME+1.
  - Main green (00) has no dwell limit; it is the rest state.
- **Sequence checking after an invalid sample:** if P is invalid (after reset or after an invalid sample), the transition check is skipped for that sample.
- **Fault latch:**
  - The first fault sets `fault`=1 and `fault_code`.
  - Later faults do not overwrite the code.
  - Checks keep running while latched.
- **Clear:** `clear_fault`=1 clears `fault` and `fault_code` to 0 only if the current sample has no violation. Otherwise the request is ignored and the code is kept.
- **Flash:**
  - While `fault`=1, `flash` toggles every FLASH_HALF cycles, starting high on the cycle `fault` rises.
  - On clear, `flash` goes to 0 and the flash counter resets.

## Timing
- **Reset values:** `phase`=00, `phase_valid`=0, `fault`=0, `fault_code`=0, `flash`=0; dwell counter, flash counter and input register all 0.
- **Reset assertion:** takes effect immediately (asynchronous).
- **Decode latency:** lamps sampled at edge N appear as `phase`/`phase_valid` after edge N+1.
- **Fault latency:** a violation in lamps sampled at edge N raises `fault`/`fault_code` after edge N+1, i.e. 2 edges from the input change.
- **Overrun timing:** dwell overruns flag on the edge where the held phase's sample count would exceed its limit.
  - Yellow held exactly YELLOW_LIFETIME samples: no fault.
  - Yellow held YELLOW_LIFETIME+1 samples: fault.
- **Clear latency:** `clear_fault` sampled at edge M drops `fault` and `flash` after edge M.
- **Simultaneous fault and clear:** a fault detected on the same edge as a clear request wins; it latches the new code.
- **Reset mid-fault:** clears everything. The first sample after reset is treated as startup, so no transition check is made.

## Test plan
1. **Legal full cycle.** GREEN=10, YELLOW=3. Drive 00×15, 10×3, 11×10, 01×3, 00×5 → `fault`=0 throughout; `phase` tracks the inputs one cycle later.
2. **Conflict.** Drive main green with side green for 1 cycle → `fault_code`=2 two edges later; `flash` pattern is 4 high, 4 low while the fault stays latched.
3. **Illegal transition and preemption.** Drive 00→11 → code 3. After reset, drive 11→00 and 10→00 → no fault (preemption is legal).
4. **Yellow timing.**
   - 10 held 4 cycles → code 4 on the 4th sample.
   - Separate run: 10 held 2 cycles then 11 → code 4.
   - Separate run: 11 held 11 cycles → code 5.
5. **Priority and sticky.**
   - Drive main red+green with side green in one sample → code 1, not 2.
   - A later conflict keeps the code at 1.
6. **Clear and reset.**
   - `clear_fault` while the lamps are still illegal → fault is kept.
   - `clear_fault` with lamps at 00 → `fault`=0, `flash`=0.
   - `rst` low mid-flash → all outputs at reset values immediately.

Source files
------------

// File: rtl/traffic_conflict_monitor.sv
// Safety monitor for the traffic light lamps. It decodes the registered lamp pattern into a phase
// and checks it for lamp integrity, conflicts, sequence and dwell. The first fault latches and flashes.
module traffic_conflict_monitor #(
    parameter int GREEN_LIFETIME  = 10,
    parameter int YELLOW_LIFETIME = 3,
    parameter int FLASH_HALF      = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       main_red,
    input  logic       main_yellow,
    input  logic       main_green,
    input  logic       side_red,
    input  logic       side_yellow,
    input  logic       side_green,
    input  logic       clear_fault,
    output logic [1:0] phase,
    output logic       phase_valid,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic       flash
);

    localparam int DWELL_SAT = GREEN_LIFETIME + YELLOW_LIFETIME + 2;
    localparam int DWELL_W   = $clog2(DWELL_SAT) + 1;
    localparam int FLASH_W   = $clog2(FLASH_HALF) + 1;

    localparam logic [DWELL_W-1:0] DWELL_MAX    = DWELL_W'(DWELL_SAT);
    localparam logic [DWELL_W-1:0] YELLOW_LIMIT = DWELL_W'(YELLOW_LIFETIME);
    localparam logic [DWELL_W-1:0] GREEN_LIMIT  = DWELL_W'(GREEN_LIFETIME);
    localparam logic [DWELL_W-1:0] DWELL_ONE    = DWELL_W'(1);
    localparam logic [FLASH_W-1:0] FLASH_LAST   = FLASH_W'(FLASH_HALF - 1);
    localparam logic [FLASH_W-1:0] FLASH_ONE    = FLASH_W'(1);

    localparam logic [1:0] PH_MAIN_GREEN  = 2'b00;
    localparam logic [1:0] PH_MAIN_YELLOW = 2'b10;
    localparam logic [1:0] PH_SIDE_GREEN  = 2'b11;
    localparam logic [1:0] PH_SIDE_YELLOW = 2'b01;

    localparam logic [2:0] CODE_NONE       = 3'd0;
    localparam logic [2:0] CODE_INTEGRITY  = 3'd1;
    localparam logic [2:0] CODE_CONFLICT   = 3'd2;
    localparam logic [2:0] CODE_TRANSITION = 3'd3;
    localparam logic [2:0] CODE_YELLOW     = 3'd4;
    localparam logic [2:0] CODE_GREEN      = 3'd5;

    // Lamp sample layout: {main_red, main_yellow, main_green, side_red, side_yellow, side_green}
    logic [5:0]         lamp_reg;
    logic               sample_loaded_reg;
    logic [1:0]         phase_reg;
    logic               phase_valid_reg;
    logic [DWELL_W-1:0] dwell_reg;
    logic               fault_reg;
    logic [2:0]         fault_code_reg;
    logic               flash_reg;
    logic [FLASH_W-1:0] flash_cnt_reg;

    logic [DWELL_W-1:0] dwell_next;
    logic               fault_next;
    logic [2:0]         fault_code_next;
    logic               flash_next;
    logic [FLASH_W-1:0] flash_cnt_next;

    logic [1:0]         s_phase;
    logic               s_valid;
    logic               same_phase;
    logic               trans_legal;
    logic [DWELL_W-1:0] dwell_inc;
    logic [1:0][2:0]    road_lamps;
    logic [1:0]         road_one_lit;
    logic [1:0]         road_red;
    logic               viol_integrity;
    logic               viol_conflict;
    logic               viol_transition;
    logic               viol_yellow;
    logic               viol_green;
    logic               any_viol;
    logic [2:0]         viol_code;

    assign road_lamps[0] = lamp_reg[5:3];
    assign road_lamps[1] = lamp_reg[2:0];

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_road
            assign road_one_lit[gi] = (road_lamps[gi] == 3'b001) || (road_lamps[gi] == 3'b010) ||
                                      (road_lamps[gi] == 3'b100);
            assign road_red[gi]     = road_lamps[gi][2];
        end
    endgenerate

    always_comb begin
        s_valid = 1'b1;
        s_phase = PH_MAIN_GREEN;
        case (lamp_reg)
            6'b001_100: s_phase = PH_MAIN_GREEN;
            6'b010_100: s_phase = PH_MAIN_YELLOW;
            6'b100_001: s_phase = PH_SIDE_GREEN;
            6'b100_010: s_phase = PH_SIDE_YELLOW;
            default: begin
                s_valid = 1'b0;
                s_phase = phase_reg;
            end
        endcase
    end

    // Holding a phase is always legal, and so is dropping back to main green.
    always_comb begin
        trans_legal = (s_phase == phase_reg) || (s_phase == PH_MAIN_GREEN);
        case (phase_reg)
            PH_MAIN_GREEN:  if (s_phase == PH_MAIN_YELLOW) trans_legal = 1'b1;
            PH_MAIN_YELLOW: if (s_phase == PH_SIDE_GREEN)  trans_legal = 1'b1;
            PH_SIDE_GREEN:  if (s_phase == PH_SIDE_YELLOW) trans_legal = 1'b1;
            default:        ;
        endcase
    end

    assign same_phase = phase_valid_reg && s_valid && (s_phase == phase_reg);
    assign dwell_inc  = (dwell_reg >= DWELL_MAX) ? DWELL_MAX : dwell_reg + DWELL_ONE;

    always_comb begin
        dwell_next = '0;
        if (s_valid) begin
            dwell_next = same_phase ? dwell_inc : DWELL_ONE;
        end
    end

    assign viol_integrity  = !(&road_one_lit);
    assign viol_conflict   = !(|road_red);
    assign viol_transition = phase_valid_reg && s_valid && !trans_legal;
    assign viol_yellow     = (same_phase && (s_phase == PH_MAIN_YELLOW || s_phase == PH_SIDE_YELLOW) &&
                              (dwell_inc > YELLOW_LIMIT)) ||
                             (phase_valid_reg && s_valid && phase_reg == PH_MAIN_YELLOW &&
                              s_phase == PH_SIDE_GREEN && dwell_reg < YELLOW_LIMIT);
    assign viol_green      = same_phase && (s_phase == PH_SIDE_GREEN) && (dwell_inc > GREEN_LIMIT);

    // The all-zero reset contents of the input register are not a real sample.
    always_comb begin
        viol_code = CODE_NONE;
        if (viol_integrity)       viol_code = CODE_INTEGRITY;
        else if (viol_conflict)   viol_code = CODE_CONFLICT;
        else if (viol_transition) viol_code = CODE_TRANSITION;
        else if (viol_yellow)     viol_code = CODE_YELLOW;
        else if (viol_green)      viol_code = CODE_GREEN;
        any_viol = sample_loaded_reg && (viol_code != CODE_NONE);
    end

    always_comb begin
        fault_next      = fault_reg;
        fault_code_next = fault_code_reg;
        if (any_viol) begin
            if (!fault_reg) begin
                fault_next      = 1'b1;
                fault_code_next = viol_code;
            end
        end else if (clear_fault) begin
            fault_next      = 1'b0;
            fault_code_next = CODE_NONE;
        end
    end

    always_comb begin
        flash_next     = 1'b0;
        flash_cnt_next = '0;
        if (fault_next) begin
            if (!fault_reg) begin
                flash_next = 1'b1;
            end else if (flash_cnt_reg >= FLASH_LAST) begin
                flash_next = !flash_reg;
            end else begin
                flash_next     = flash_reg;
                flash_cnt_next = flash_cnt_reg + FLASH_ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lamp_reg          <= '0;
            sample_loaded_reg <= 1'b0;
            phase_reg         <= PH_MAIN_GREEN;
            phase_valid_reg   <= 1'b0;
            dwell_reg         <= '0;
            fault_reg         <= 1'b0;
            fault_code_reg    <= CODE_NONE;
            flash_reg         <= 1'b0;
            flash_cnt_reg     <= '0;
        end else begin
            lamp_reg          <= {main_red, main_yellow, main_green, side_red, side_yellow, side_green};
            sample_loaded_reg <= 1'b1;
            phase_reg         <= s_phase;
            phase_valid_reg   <= s_valid;
            dwell_reg         <= dwell_next;
            fault_reg         <= fault_next;
            fault_code_reg    <= fault_code_next;
            flash_reg         <= flash_next;
            flash_cnt_reg     <= flash_cnt_next;
        end
    end

    assign phase       = phase_reg;
    assign phase_valid = phase_valid_reg;
    assign fault       = fault_reg;
    assign fault_code  = fault_code_reg;
    assign flash       = flash_reg;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: table of lamp samples with expected outputs through a
// scoreboard queue, followed by hand-written clear and reset sequences.
`timescale 1ns/1ps
module tb_traffic_conflict_monitor;

    localparam int G = 10;
    localparam int Y = 3;
    localparam int H = 4;

    localparam logic [5:0] L00  = 6'b001_100;
    localparam logic [5:0] L10  = 6'b010_100;
    localparam logic [5:0] L11  = 6'b100_001;
    localparam logic [5:0] L01  = 6'b100_010;
    localparam logic [5:0] LCF  = 6'b001_001;
    localparam logic [5:0] LRG  = 6'b101_001;
    localparam logic [5:0] LTIE = 6'b011_001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic main_red = 1'b0, main_yellow = 1'b0, main_green = 1'b0;
    logic side_red = 1'b0, side_yellow = 1'b0, side_green = 1'b0;
    logic clear_fault = 1'b0;
    logic [1:0] phase;
    logic phase_valid, fault, flash;
    logic [2:0] fault_code;

    always #5 clk = ~clk;

    traffic_conflict_monitor #(
        .GREEN_LIFETIME(G), .YELLOW_LIFETIME(Y), .FLASH_HALF(H)
    ) dut (
        .clk(clk), .rst(rst),
        .main_red(main_red), .main_yellow(main_yellow), .main_green(main_green),
        .side_red(side_red), .side_yellow(side_yellow), .side_green(side_green),
        .clear_fault(clear_fault),
        .phase(phase), .phase_valid(phase_valid), .fault(fault),
        .fault_code(fault_code), .flash(flash)
    );

    typedef struct {
        logic       new_seg;
        logic [5:0] lamps;
        int         rep;
        logic [1:0] ph;
        logic       pv;
        logic       flt;
        logic [2:0] code;
    } vec_t;

    typedef struct {
        logic [1:0] ph;
        logic       pv;
        logic       flt;
        logic [2:0] code;
        int         row;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_flt;
    int   age;

    task automatic add(input logic ns, input logic [5:0] l, input int n, input logic [1:0] ph,
                       input logic pv, input logic f, input logic [2:0] c);
        vecs.push_back('{ns, l, n, ph, pv, f, c});
    endtask

    task automatic set_lamps(input logic [5:0] l);
        {main_red, main_yellow, main_green, side_red, side_yellow, side_green} = l;
    endtask

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end else begin
            $display("ok   %s value=%0d", name, act);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        @(negedge clk);
        rst = 1'b0;
        clear_fault = 1'b0;
        set_lamps(L00);
        tick();
        chk("reset_phase", phase, 0);
        chk("reset_phase_valid", phase_valid, 0);
        chk("reset_fault", fault, 0);
        chk("reset_code", fault_code, 0);
        chk("reset_flash", flash, 0);
        @(negedge clk);
        rst = 1'b1;
        prev_flt = 1'b0;
        age = 0;
    endtask

    // Flash is high for the first H cycles after the fault rises, then alternates every H cycles.
    task automatic compare(input exp_t e);
        logic exp_flash;
        if (e.flt && !prev_flt) age = 0;
        else if (e.flt)         age++;
        prev_flt  = e.flt;
        exp_flash = e.flt && (((age / H) % 2) == 0);
        chk($sformatf("row%0d_phase", e.row), phase, e.ph);
        chk($sformatf("row%0d_phase_valid", e.row), phase_valid, e.pv);
        chk($sformatf("row%0d_fault", e.row), fault, e.flt);
        chk($sformatf("row%0d_code", e.row), fault_code, e.code);
        chk($sformatf("row%0d_flash", e.row), flash, exp_flash);
    endtask

    task automatic flush;
        if (sb.size() > 0) begin
            tick();
            while (sb.size() > 0) compare(sb.pop_front());
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Legal full cycle
        add(1, L00, 15, 2'b00, 1, 0, 0);
        add(0, L10,  3, 2'b10, 1, 0, 0);
        add(0, L11, 10, 2'b11, 1, 0, 0);
        add(0, L01,  3, 2'b01, 1, 0, 0);
        add(0, L00,  5, 2'b00, 1, 0, 0);
        // Conflict, then flash pattern while latched
        add(1, L00,  3, 2'b00, 1, 0, 0);
        add(0, LCF,  1, 2'b00, 0, 1, 2);
        add(0, L00,  9, 2'b00, 1, 1, 2);
        // Illegal 00 -> 11
        add(1, L00,  2, 2'b00, 1, 0, 0);
        add(0, L11,  1, 2'b11, 1, 1, 3);
        add(0, L11,  2, 2'b11, 1, 1, 3);
        // Preemption to main green is legal
        add(1, L11,  2, 2'b11, 1, 0, 0);
        add(0, L00,  1, 2'b00, 1, 0, 0);
        add(0, L10,  2, 2'b10, 1, 0, 0);
        add(0, L00,  2, 2'b00, 1, 0, 0);
        // Main yellow overrun on 4th sample
        add(1, L00,  1, 2'b00, 1, 0, 0);
        add(0, L10,  3, 2'b10, 1, 0, 0);
        add(0, L10,  1, 2'b10, 1, 1, 4);
        // Short yellow before side green
        add(1, L00,  1, 2'b00, 1, 0, 0);
        add(0, L10,  2, 2'b10, 1, 0, 0);
        add(0, L11,  1, 2'b11, 1, 1, 4);
        // Side green overrun on 11th sample
        add(1, L00,  1, 2'b00, 1, 0, 0);
        add(0, L10,  3, 2'b10, 1, 0, 0);
        add(0, L11, 10, 2'b11, 1, 0, 0);
        add(0, L11,  1, 2'b11, 1, 1, 5);
        // Integrity wins and sticks over a later conflict
        add(1, L00,  2, 2'b00, 1, 0, 0);
        add(0, LRG,  1, 2'b00, 0, 1, 1);
        add(0, LCF,  1, 2'b00, 0, 1, 1);
        add(0, L00,  2, 2'b00, 1, 1, 1);
        // Same-sample integrity and conflict tie
        add(1, L00,  1, 2'b00, 1, 0, 0);
        add(0, LTIE, 1, 2'b00, 0, 1, 1);
        // Side yellow overrun
        add(1, L00,  1, 2'b00, 1, 0, 0);
        add(0, L10,  3, 2'b10, 1, 0, 0);
        add(0, L11,  2, 2'b11, 1, 0, 0);
        add(0, L01,  3, 2'b01, 1, 0, 0);
        add(0, L01,  1, 2'b01, 1, 1, 4);

        foreach (vecs[i]) begin
            if (vecs[i].new_seg) begin
                flush();
                do_reset();
            end
            for (int r = 0; r < vecs[i].rep; r++) begin
                set_lamps(vecs[i].lamps);
                sb.push_back('{vecs[i].ph, vecs[i].pv, vecs[i].flt, vecs[i].code, i});
                tick();
                if (sb.size() >= 2) compare(sb.pop_front());
            end
        end
        flush();

        // Clear handling
        do_reset();
        set_lamps(L00);
        tick();
        set_lamps(LCF);
        tick();
        tick();
        chk("clr_fault_set", fault, 1);
        chk("clr_code_set", fault_code, 2);
        chk("clr_flash_set", flash, 1);
        clear_fault = 1'b1;
        tick();
        chk("clr_ignored_fault", fault, 1);
        chk("clr_ignored_code", fault_code, 2);
        clear_fault = 1'b0;
        set_lamps(L00);
        tick();
        chk("clr_pending_fault", fault, 1);
        clear_fault = 1'b1;
        tick();
        chk("clr_done_fault", fault, 0);
        chk("clr_done_code", fault_code, 0);
        chk("clr_done_flash", flash, 0);
        chk("clr_done_phase_valid", phase_valid, 1);
        clear_fault = 1'b0;
        tick();
        chk("clr_stays_clear", fault, 0);
        // Fault and clear on the same edge: the fault wins
        set_lamps(LCF);
        tick();
        set_lamps(L00);
        clear_fault = 1'b1;
        tick();
        chk("simul_fault", fault, 1);
        chk("simul_code", fault_code, 2);
        chk("simul_flash", flash, 1);
        clear_fault = 1'b0;
        tick();
        tick();
        // Asynchronous reset mid-flash
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_rst_phase", phase, 0);
        chk("async_rst_phase_valid", phase_valid, 0);
        chk("async_rst_fault", fault, 0);
        chk("async_rst_code", fault_code, 0);
        chk("async_rst_flash", flash, 0);
        set_lamps(L11);
        @(negedge clk);
        rst = 1'b1;
        tick();
        tick();
        chk("startup_no_transition_fault", fault, 0);
        chk("startup_phase", phase, 3);
        chk("startup_phase_valid", phase_valid, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
